rv32m_div_unit: RTL

- Iterative radix-2 restoring divider for RV32M DIV, DIVU, REM and REMU.
- Sits in EX/MEM alongside the ALU. Its registered result feeds the writeback result-select mux as one of its 32-bit signed inputs.
- The pipeline control uses busy to stall the front end while a division is in flight.

---
 rtl/rv32m_div_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rv32m_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle on operand magnitudes, sign-corrected at the end.
module rv32m_div_unit #(
  parameter int XLEN = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             op,
  input  logic [XLEN-1:0]        dividend,
  input  logic [XLEN-1:0]        divisor,
  input  logic                   flush,
  output logic                   busy,
  output logic                   done,
  output logic signed [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_reg;
  logic [XLEN-1:0] quot_reg;
  logic [XLEN:0]   rem_reg;
  logic [XLEN:0]   dvs_reg;
  logic [CW-1:0]   count_reg;
  logic            rem_op_reg;
  logic            neg_q_reg;
  logic            neg_r_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [XLEN-1:0] result_reg;

  // Operand decode for the accepting edge
  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN:0]   b_mag;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] special_val;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & dividend[XLEN-1];
  assign b_neg     = is_signed & divisor[XLEN-1];
  assign a_mag     = a_neg ? (~dividend + XLEN'(1)) : dividend;
  assign b_mag     = {1'b0, (b_neg ? (~divisor + XLEN'(1)) : divisor)};
  assign div_zero  = (divisor == '0);
  assign overflow  = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                     && (divisor == {XLEN{1'b1}});

  // Divide-by-zero wins over overflow; overflow quotient is the dividend itself
  always_comb begin
    special_val = '0;
    if (div_zero)
      special_val = op[1] ? dividend : {XLEN{1'b1}};
    else if (overflow)
      special_val = op[1] ? '0 : dividend;
  end

  // One restoring step: the 33-bit compare keeps |-2^31| exact
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic            ge;
  logic [XLEN:0]   rem_next;
  logic [XLEN-1:0] quot_next;
  logic [XLEN-1:0] q_final;
  logic [XLEN-1:0] r_final;

  assign shifted   = {rem_reg[XLEN-1:0], quot_reg[XLEN-1]};
  assign trial     = shifted - dvs_reg;
  assign ge        = (shifted >= dvs_reg);
  assign rem_next  = ge ? trial : shifted;
  assign quot_next = {quot_reg[XLEN-2:0], ge};
  assign q_final   = neg_q_reg ? (XLEN'(0) - quot_next) : quot_next;
  assign r_final   = neg_r_reg ? (XLEN'(0) - rem_next[XLEN-1:0]) : rem_next[XLEN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      quot_reg   <= '0;
      rem_reg    <= '0;
      dvs_reg    <= '0;
      count_reg  <= '0;
      rem_op_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else if (flush) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            rem_op_reg <= op[1];
            neg_q_reg  <= a_neg ^ b_neg;
            neg_r_reg  <= a_neg;
            dvs_reg    <= b_mag;
            quot_reg   <= a_mag;
            rem_reg    <= '0;
            count_reg  <= '0;
            if (div_zero || overflow) begin
              result_reg <= special_val;
              state_reg  <= DONE;
              done_reg   <= 1'b1;
            end else begin
              state_reg <= CALC;
              busy_reg  <= 1'b1;
            end
          end
        end
        CALC: begin
          rem_reg   <= rem_next;
          quot_reg  <= quot_next;
          count_reg <= count_reg + CW'(1);
          if (count_reg == CW'(XLEN - 1)) begin
            result_reg <= rem_op_reg ? r_final : q_final;
            state_reg  <= DONE;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;

endmodule
